or_operand_collector: RTL and testbench

//   Serial-to-parallel operand collector directly upstream of the 4-input OR chain stage.

---
 rtl/or_chain_pkg.sv | 14 +
 rtl/or_operand_collector.sv | 110 +++++++++++
 tb/tb_or_operand_collector.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/or_chain_pkg.sv
// Shared definitions for the 4-input OR chain: lane count, collector FSM
// state encoding and the slot index type used by the operand collector.
package or_chain_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } collect_state_t;

    typedef logic [1:0] lane_idx_t;

endpackage : or_chain_pkg

// File: rtl/or_operand_collector.sv
// or_operand_collector: serial-to-parallel operand collector feeding the
// 4-input OR stage. Words arrive one per beat on s_*, fill slots m_in1..m_in4
// in order, and the completed group is presented on m_* until accepted.
// Optional feature macro: OR_COLLECT_FLUSH_EN adds a flush input that closes
// a partial group, padding unwritten slots with 0 (the OR-neutral value).
// dbg_state / dbg_cnt expose the FSM state and slot counter for observation.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. A source holds data/valid stable until the transfer; ready never
// depends on the same interface's valid. s_ready depends on m_ready so a held
// group can be released and the next word taken on the same edge.
module or_operand_collector
    import or_chain_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_in1,
    output logic [WIDTH-1:0] m_in2,
    output logic [WIDTH-1:0] m_in3,
    output logic [WIDTH-1:0] m_in4,
    output logic             m_valid,
    input  logic             m_ready,
`ifdef OR_COLLECT_FLUSH_EN
    input  logic             flush,
`endif
    output collect_state_t   dbg_state,
    output lane_idx_t        dbg_cnt
);

    collect_state_t   state;
    lane_idx_t        cnt;
    logic [WIDTH-1:0] slot [NUM_LANES];
    logic             accept;
    logic             last_beat;
    logic             flush_close;

    // Ready whenever filling, or when the held group leaves this cycle.
    assign s_ready   = (state == FILL) | ((state == HOLD) & m_ready);
    assign accept    = s_valid & s_ready;
    assign last_beat = (cnt == lane_idx_t'(NUM_LANES - 1));

`ifdef OR_COLLECT_FLUSH_EN
    // Flush only closes a group that has (or is just receiving) a word.
    assign flush_close = (state == FILL) & flush & ((cnt != lane_idx_t'(0)) | accept);
`else
    assign flush_close = 1'b0;
`endif

    // Slot registers drive the OR stage directly.
    assign m_in1     = slot[0];
    assign m_in2     = slot[1];
    assign m_in3     = slot[2];
    assign m_in4     = slot[3];
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

    // Collector FSM: slot writes, counter, state and registered m_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            cnt     <= '0;
            m_valid <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                slot[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (accept && (lane_idx_t'(i) == cnt)) begin
                            slot[i] <= s_data;
                        end else if (flush_close && (i >= int'(cnt))) begin
                            slot[i] <= '0;
                        end
                    end
                    if (flush_close || (accept && last_beat)) begin
                        state   <= HOLD;
                        m_valid <= 1'b1;
                        cnt     <= '0;
                    end else if (accept) begin
                        cnt <= cnt + lane_idx_t'(1);
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        state   <= FILL;
                        m_valid <= 1'b0;
                        if (accept) begin
                            slot[0] <= s_data;
                            cnt     <= lane_idx_t'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                default: begin
                    state   <= FILL;
                    m_valid <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule : or_operand_collector

// File: tb/tb_or_operand_collector.sv
// Testbench for or_operand_collector (WIDTH=4). Directed vectors plus a
// random valid/ready stress; a monitor pops expected groups on every
// m_valid & m_ready transfer. Build with OR_COLLECT_FLUSH_EN to cover flush.
module tb_or_operand_collector;
    import or_chain_pkg::*;

    localparam int W  = 4;
    localparam int GW = 4 * W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]   s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   m_in1, m_in2, m_in3, m_in4;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic           flush = 1'b0;
    collect_state_t dbg_state;
    lane_idx_t      dbg_cnt;

    or_operand_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_in1     (m_in1),
        .m_in2     (m_in2),
        .m_in3     (m_in3),
        .m_in4     (m_in4),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
`ifdef OR_COLLECT_FLUSH_EN
        .flush     (flush),
`endif
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [GW-1:0] exp_q[$];
    logic [W-1:0]  buf_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic          stress_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pack the buffered words into a group, zero-padding missing slots.
    task automatic close_group();
        logic [GW-1:0] grp;
        grp = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < buf_q.size()) grp[(3-i)*W +: W] = buf_q[i];
        end
        exp_q.push_back(grp);
        buf_q.delete();
    endtask

    task automatic model_accept(input logic [W-1:0] d, input logic fl);
        buf_q.push_back(d);
        if (buf_q.size() == 4 || fl) close_group();
    endtask

    task automatic model_flush();
        if (buf_q.size() > 0) close_group();
    endtask

    // Monitor: compare every transferred group with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_group", {m_in1, m_in2, m_in3, m_in4}, 32'hDEAD);
            end else begin
                logic [GW-1:0] e;
                e = exp_q.pop_front();
                check("group", {m_in1, m_in2, m_in3, m_in4}, 32'(e));
                check("or_out", 32'(m_in1 | m_in2 | m_in3 | m_in4),
                      32'(e[15:12] | e[11:8] | e[7:4] | e[3:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [W-1:0] d);
        int   n;
        logic took;
        logic fl;
        n = 0;
        took = 1'b0;
        fl = 1'b0;
        s_data = d;
        s_valid = 1'b1;
        while (!took && n < 200) begin
            @(negedge clk);
            took = s_ready;
            fl = flush;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (!took) check("beat_timeout", 32'(n), 32'(0));
        else model_accept(d, fl);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        model_flush();
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'(0));
        check("rst_m_in", {m_in1, m_in2, m_in3, m_in4}, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(FILL));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_s_ready", 32'(s_ready), 32'(1));
        check("rst_cnt", 32'(dbg_cnt), 32'(0));

        // Basic group, consumer always ready.
        m_ready = 1'b1;
        send_beat(4'h1);
        send_beat(4'h2);
        send_beat(4'h4);
        send_beat(4'h8);
        check("latency_m_valid", 32'(m_valid), 32'(1));
        check("latency_state", 32'(dbg_state), 32'(HOLD));
        step();
        check("released_m_valid", 32'(m_valid), 32'(0));

        // Back-pressure: group held for 5 cycles while upstream wiggles.
        m_ready = 1'b0;
        send_beat(4'hA);
        send_beat(4'hB);
        send_beat(4'hC);
        send_beat(4'hD);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("hold_m_valid", 32'(m_valid), 32'(1));
            check("hold_s_ready", 32'(s_ready), 32'(0));
            check("hold_m_in", {m_in1, m_in2, m_in3, m_in4}, 32'hABCD);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("release_s_ready", 32'(s_ready), 32'(1));
        step();
        check("release_m_valid", 32'(m_valid), 32'(0));

        // Release and new word on the same edge.
        m_ready = 1'b0;
        send_beat(4'h9);
        send_beat(4'hA);
        send_beat(4'hB);
        send_beat(4'hC);
        m_ready = 1'b1;
        send_beat(4'h3);
        check("same_edge_m_valid", 32'(m_valid), 32'(0));
        check("same_edge_m_in1", 32'(m_in1), 32'h3);
        check("same_edge_cnt", 32'(dbg_cnt), 32'(1));
        check("same_edge_state", 32'(dbg_state), 32'(FILL));
        send_beat(4'h1);
        send_beat(4'h2);
        send_beat(4'h4);

        // Asynchronous reset in the middle of a group.
        send_beat(4'h5);
        send_beat(4'h6);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", 32'(m_valid), 32'(0));
        check("async_rst_m_in", {m_in1, m_in2, m_in3, m_in4}, 32'h0);
        check("async_rst_cnt", 32'(dbg_cnt), 32'(0));
        buf_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_s_ready", 32'(s_ready), 32'(1));
        send_beat(4'h7);
        send_beat(4'h8);
        send_beat(4'h9);
        send_beat(4'hA);
        step();

`ifdef OR_COLLECT_FLUSH_EN
        // Flush a partial group of two words.
        m_ready = 1'b0;
        send_beat(4'h5);
        send_beat(4'h6);
        do_flush();
        check("flush_m_valid", 32'(m_valid), 32'(1));
        check("flush_m_in", {m_in1, m_in2, m_in3, m_in4}, 32'h5600);
        m_ready = 1'b1;
        step();
        // Flush with an empty group is ignored.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("idle_flush_m_valid", 32'(m_valid), 32'(0));
        step();
        check("idle_flush_m_valid2", 32'(m_valid), 32'(0));
        check("idle_flush_state", 32'(dbg_state), 32'(FILL));
        // Flush together with the first word of a group.
        flush = 1'b1;
        send_beat(4'h7);
        flush = 1'b0;
        check("flush_accept_m_valid", 32'(m_valid), 32'(1));
        check("flush_accept_m_in", {m_in1, m_in2, m_in3, m_in4}, 32'h7000);
        step();
`endif

        // Random valid/ready stress.
        stress_on = 1'b1;
        fork
            begin
                for (int b = 0; b < 10000; b++) begin
                    send_beat(4'($urandom_range(0, 15)));
                    repeat ($urandom_range(0, 2)) step();
                end
                stress_on = 1'b0;
            end
            begin
                while (stress_on) begin
                    m_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
            end
        join

        // Drain whatever is still held.
        m_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() > 0; n++) step();
        check("drain_exp_q_empty", 32'(exp_q.size()), 32'(0));
        check("drain_partial_empty", 32'(buf_q.size()), 32'(0));
        step();
        check("final_m_valid", 32'(m_valid), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_or_operand_collector
